// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register for use between processor stages (IF/ID,
// ID/EX, EX/MEM, MEM/WB). It carries an opaque DATA_W-bit payload; callers
// pack and unpack their own fields.
//
// Each side uses a valid/ready handshake. A 2-entry skid buffer (main + skid)
// lets the stage sustain one transfer per cycle while in_ready comes straight
// from a flop. As a result, no combinational path runs from out_ready back to
// the upstream stage.
//
// Optional feature, enabled by defining PIPE_STAGE_PERF_EN:
//   stall_cnt / bubble_cnt performance counters. They saturate and clear
//   only on rst. When the macro is undefined, both ports are tied to zero.
//
// Parameters:
//   DATA_W   payload width in bits (>= 1)
//   RST_VAL  payload register value after reset
//   CNT_W    performance counter width
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (highest priority)
//   flush       discard all held entries; payload registers keep old values
//   in_valid    upstream offers in_data
//   in_ready    stage can accept (registered)
//   in_data     upstream payload, sampled only on in_valid & in_ready
//   out_valid   out_data is valid
//   out_ready   downstream accepts
//   out_data    payload to downstream (registered, stable while stalled)
//   stall_cnt   cycles with out_valid=1 and out_ready=0
//   bubble_cnt  cycles with out_valid=0
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int                CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Occupancy encoded as {m_v, s_v}. The code 2'b01 (skid full, main empty)
  // can never be reached: the skid entry is only filled while main is held.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b10,
    OCC_FULL  = 2'b11
  } occ_e;

  occ_e              state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] m_d, s_d;
  logic              m_v, s_v;
  logic              in_fire, out_fire;

  // Payload steering decided by the control process.
  logic              ld_m_from_in;
  logic              ld_m_from_skid;
  logic              ld_s_from_in;

  assign m_v      = (state_q != OCC_EMPTY);
  assign s_v      = (state_q == OCC_FULL);

  assign in_ready  = in_ready_q;
  assign out_valid = m_v;
  assign out_data  = m_d;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = m_v & out_ready;

  // ---------------------------------------------------------------------------
  // Next-state and payload steering
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d        = state_q;
    ld_m_from_in   = 1'b0;
    ld_m_from_skid = 1'b0;
    ld_s_from_in   = 1'b0;

    if (flush) begin
      // A same-cycle in_fire is acknowledged but dropped: no load is enabled.
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            state_d      = OCC_ONE;
            ld_m_from_in = 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            ld_m_from_in = 1'b1;          // replace the departing entry
          end else if (in_fire) begin
            state_d      = OCC_FULL;      // main is stalled; park in skid
            ld_s_from_in = 1'b1;
          end else if (out_fire) begin
            state_d      = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only draining is possible.
          if (out_fire) begin
            state_d        = OCC_ONE;
            ld_m_from_skid = 1'b1;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // in_ready is computed from the next state so that it is a plain flop
  // output. It reads as !s_v at all times.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != OCC_FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Payload registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: payload registers are reset so that out_data shows a defined
    // RST_VAL after reset. Flush deliberately leaves them untouched, because
    // the valid bits alone decide whether the contents mean anything.
    if (rst) begin
      m_d <= RST_VAL;
      s_d <= RST_VAL;
    end else begin
      if (ld_m_from_in) begin
        m_d <= in_data;
      end else if (ld_m_from_skid) begin
        m_d <= s_d;
      end
      if (ld_s_from_in) begin
        s_d <= in_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q, bubble_q;

  // Counts cover cycles up to and including the previous edge. They saturate
  // rather than wrap, and flush does not affect them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (m_v && !out_ready && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (!m_v && (bubble_q != CNT_MAX)) begin
        bubble_q <= bubble_q + CNT_ONE;
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed testbench for pipe_stage_reg (DATA_W=8, RST_VAL=8'h5A, CNT_W=4).
// Every expected value below is hand-derived from the stage's behaviour.
// Counter expectations are zero unless PIPE_STAGE_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          DATA_W  = 8;
  localparam logic [7:0]  RST_VAL = 8'h5A;
  localparam int          CNT_W   = 4;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .RST_VAL(RST_VAL),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge. The stage
  // must never show "skid full, main empty": out_valid=0 with in_ready=0.
  task automatic tick();
    @(posedge clk);
    #1;
    check("no_state_01", {31'd0, out_valid | in_ready}, 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d, input logic r);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".out_data"},  {24'd0, out_data},  {24'd0, d});
    check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, r});
  endtask

  task automatic expect_cnt(input string tag, input int stall, input int bubble);
    check({tag, ".stall_cnt"},  {28'd0, stall_cnt},  PERF ? stall  : 0);
    check({tag, ".bubble_cnt"}, {28'd0, bubble_cnt}, PERF ? bubble : 0);
  endtask

  logic [7:0] stream_vec [4];

  initial begin
    stream_vec[0] = 8'h11;
    stream_vec[1] = 8'h22;
    stream_vec[2] = 8'h33;
    stream_vec[3] = 8'h44;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // ---- Reset and idle ----
    tick();
    tick();
    expect_out("reset", 1'b0, RST_VAL, 1'b1);
    expect_cnt("reset", 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("idle", 1'b0, RST_VAL, 1'b1);
    end
    expect_cnt("idle", 0, 5);

    // ---- Streaming, out_ready held high ----
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = stream_vec[i];
      tick();
      expect_out("stream", 1'b1, stream_vec[i], 1'b1);
    end
    in_valid = 1'b0;
    tick();
    expect_out("stream_end", 1'b0, 8'h44, 1'b1);

    // ---- Backpressure and skid ----
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'hA1;
    tick();
    expect_out("bp_a1", 1'b1, 8'hA1, 1'b1);
    in_data = 8'hA2;
    tick();
    expect_out("bp_a2", 1'b1, 8'hA1, 1'b0);
    in_data = 8'hA3;                       // offered while full: refused
    tick();
    expect_out("bp_a3_refused", 1'b1, 8'hA1, 1'b0);
    check("bp.stall_cnt", {28'd0, stall_cnt}, PERF ? 2 : 0);
    out_ready = 1'b1;                      // A1 drains; A3 still refused
    tick();
    expect_out("drain_a2", 1'b1, 8'hA2, 1'b1);
    tick();                                // A3 accepted while A2 drains
    expect_out("drain_a3", 1'b1, 8'hA3, 1'b1);
    in_valid = 1'b0;
    tick();
    expect_out("drain_empty", 1'b0, 8'hA3, 1'b1);
    check("drain.stall_cnt", {28'd0, stall_cnt}, PERF ? 2 : 0);

    // ---- Full with out_ready toggling: one entry per out_fire ----
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'hF1;
    tick();
    in_data = 8'hF2;
    tick();
    expect_out("tog_full", 1'b1, 8'hF1, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_out("tog_fire1", 1'b1, 8'hF2, 1'b1);
    out_ready = 1'b0;
    tick();
    expect_out("tog_hold", 1'b1, 8'hF2, 1'b1);
    out_ready = 1'b1;
    tick();
    expect_out("tog_fire2", 1'b0, 8'hF2, 1'b1);

    // ---- Flush while full, with B3 offered alongside ----
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'hB1;
    tick();
    in_data = 8'hB2;
    tick();
    expect_out("fl_full", 1'b1, 8'hB1, 1'b0);
    flush = 1'b1; in_data = 8'hB3;
    tick();
    expect_out("fl_after", 1'b0, 8'hB1, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    expect_out("fl_no_b3", 1'b0, 8'hB1, 1'b1);

    // ---- Flush in (1,0) with an accepted in_fire: dropped ----
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'hC1;
    tick();
    flush = 1'b1; in_data = 8'hC2;         // in_ready=1, so this fires
    tick();
    expect_out("fl_drop", 1'b0, 8'hC1, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    expect_out("fl_drop_idle", 1'b0, 8'hC1, 1'b1);

    // ---- Reset mid-operation from (1,1) ----
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'hD1;
    tick();
    in_data = 8'hD2;
    tick();
    expect_out("rst_full", 1'b1, 8'hD1, 1'b0);
    in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
    tick();
    expect_out("rst_mid", 1'b0, RST_VAL, 1'b1);
    expect_cnt("rst_mid", 0, 0);
    rst = 1'b0;

    // ---- Stall counter saturation (CNT_W=4) ----
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'hE1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) check("sat_at_15", {28'd0, stall_cnt}, PERF ? 15 : 0);
    end
    expect_out("sat_hold", 1'b1, 8'hE1, 1'b1);
    expect_cnt("sat", 15, 1);
    out_ready = 1'b1;
    tick();
    expect_out("sat_drain", 1'b0, 8'hE1, 1'b1);
    check("sat_final.stall_cnt", {28'd0, stall_cnt}, PERF ? 15 : 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
